// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// through a single 1-bit full subtractor cell. The result (diff, borrow_out, zero)
// is held between operations, and done pulses for one cycle when it is valid.

// 1-bit full subtractor cell: a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one operand bit per clock, LSB first
// DONE  | result valid for one cycle, start accepted back-to-back
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;

    logic cell_d;
    logic cell_bout;

    // Operands are shifted right each RUN cycle, so bit 0 of each shift
    // register always holds operand bit [count].
    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and datapath: accept in IDLE/DONE, one bit per cycle in RUN.
    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        borrow_d     = borrow_q;
        count_d      = count_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d          = a_sh_q >> 1;
                b_sh_d          = b_sh_q >> 1;
                diff_d[count_q] = cell_d;
                borrow_d        = cell_bout;
                if (count_q == LAST_BIT) begin
                    // Counter parks at WIDTH-1; it is cleared on the next accept.
                    state_d      = S_DONE;
                    borrow_out_d = cell_bout;
                    zero_d       = (diff_d == '0);
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; zero reflects the cleared diff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: an 8-bit instance for directed
// cases (latency, back-to-back, reset abort) and a 4-bit instance swept exhaustively.
module tb_serial_subtractor_ctrl;
    typedef struct {
        logic [31:0] diff;
        logic        bo;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;

    logic       start8 = 1'b0, start4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy8, done8, bo8, zero8;
    logic       busy4, done4, bo4, zero4;
    logic [7:0] diff8;
    logic [3:0] diff4;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .zero(zero8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int w, input int av, input int bv, input int done_cyc);
        exp_t e;
        int   m;
        m      = (1 << w) - 1;
        e.diff = 32'((av - bv) & m);
        e.bo   = (av < bv);
        e.z    = (((av - bv) & m) == 0);
        e.cyc  = done_cyc;
        return e;
    endfunction

    // Compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8) begin
            check("pending_on_done8", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                check("diff8", 32'(diff8), e8.diff);
                check("borrow8", 32'(bo8), 32'(e8.bo));
                check("zero8", 32'(zero8), 32'(e8.z));
                check("latency8", 32'(cyc), 32'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            check("pending_on_done4", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("diff4", 32'(diff4), e4.diff);
                check("borrow4", 32'(bo4), 32'(e4.bo));
                check("zero4", 32'(zero4), 32'(e4.z));
            end
        end
    end

    task automatic drain8(inout int nb);
        int n = 0;
        while (q8.size() != 0 && n < 40) begin
            tick();
            if (busy8) nb++;
            n++;
        end
        if (q8.size() != 0) begin
            check("drain8_timeout", 32'(q8.size()), 32'd0);
            q8.delete();
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv);
        int   nb = 0;
        exp_t e;
        start8 = 1'b1; a8 = av; b8 = bv;
        e = model(8, int'(av), int'(bv), cyc + 1 + 8);
        q8.push_back(e);
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (busy8) nb++;
        drain8(nb);
        check("busy_cycles8", 32'(nb), 32'd8);
        repeat (2) tick();
        check("diff8_hold", 32'(diff8), e.diff);
        check("borrow8_hold", 32'(bo8), 32'(e.bo));
    endtask

    task automatic run4(input int av, input int bv);
        int n = 0;
        start4 = 1'b1; a4 = 4'(av); b4 = 4'(bv);
        q4.push_back(model(4, av, bv, 0));
        tick();
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        while (q4.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q4.size() != 0) begin
            check("drain4_timeout", 32'(q4.size()), 32'd0);
            q4.delete();
        end
    endtask

    initial begin
        int   nb;
        exp_t e;

        rst = 1'b1;
        repeat (2) tick();
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(bo8), 32'd0);
        check("rst_zero", 32'(zero8), 32'd1);
        check("rst_zero4", 32'(zero4), 32'd1);
        rst = 1'b0;

        // Directed single operations, including borrow and zero corners.
        run8(8'h5A, 8'h23);
        run8(8'h10, 8'h20);
        run8(8'h00, 8'h01);
        run8(8'h3C, 8'h3C);
        run8(8'hFF, 8'h00);
        run8(8'h00, 8'hFF);

        // Start held high: second operands presented in DONE, accepted back-to-back.
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
        q8.push_back(model(8, 5, 3, cyc + 1 + 8));
        tick();
        repeat (8) tick();
        check("b2b_done_first", 32'(done8), 32'd1);
        a8 = 8'h03; b8 = 8'h05;
        q8.push_back(model(8, 3, 5, cyc + 1 + 8));
        tick();
        a8 = 8'hAA; b8 = 8'h11;
        repeat (3) tick();
        start8 = 1'b0;
        nb = 0;
        drain8(nb);
        tick();
        check("b2b_idle_after", 32'(busy8 | done8), 32'd0);

        // Reset during the 4th RUN cycle aborts without a done pulse.
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        check("abort_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_zero", 32'(zero8), 32'd1);
        check("abort_borrow", 32'(bo8), 32'd0);
        repeat (20) tick();
        run8(8'h77, 8'h11);

        // Exhaustive 4-bit sweep.
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run4(i, j);

        repeat (2) tick();
        check("q8_empty_end", 32'(q8.size()), 32'd0);
        check("q4_empty_end", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a subtraction; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  minuend, unsigned.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-007 Port: busy  output  1  high while the state is RUN.
REQ-008 Port: done  output  1  high for exactly one cycle when the result is valid.
REQ-009 Port: diff  output  WIDTH  result a - b mod 2^WIDTH, held until next accepted start.
REQ-010 Port: borrow_out  output  1  final borrow; 1 iff a < b (unsigned), held with diff.
REQ-011 Port: zero  output  1  1 iff diff == 0, held with diff.

Function
REQ-012 The block SHALL compute a - b bit-serially, LSB first, one bit per clock, using a single instance of the team's 1-bit full subtractor cell (A, B, Bin -> Difference, Borrow) as its only arithmetic element.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: start=1 at an edge -> latch a and b into shift registers, clear the borrow register to 0, clear the bit counter to 0, go to RUN; start=0 -> stay IDLE.
REQ-015 RUN: each edge SHALL feed operand bit [count] and the borrow register into the cell, write Difference into diff bit [count], load Borrow into the borrow register, and increment count.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the FSM SHALL go to DONE and borrow_out and zero SHALL be updated.
REQ-017 DONE SHALL last one cycle with done=1; start=1 in DONE -> accepted as in IDLE and go directly to RUN (back-to-back); otherwise -> IDLE.
REQ-018 Latency: start sampled at edge E -> done=1 during the cycle following edge E+WIDTH; back-to-back throughput is one result per WIDTH+1 cycles.
REQ-019 start while in RUN SHALL be ignored; a and b changes after the accept edge SHALL NOT affect the result.
REQ-020 diff, borrow_out, zero SHALL hold their last values in IDLE and DONE; bits of diff SHALL update individually during RUN (valid only when done=1).
REQ-021 The counter SHALL be wide enough to hold WIDTH-1 without wrap; it SHALL NOT wrap during RUN.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE and clear busy, done, diff, borrow_out, the borrow register and counter to 0, and set zero to 1, regardless of state.
REQ-023 rst=1 during RUN SHALL abort the operation with no done pulse; rst takes priority over start.
REQ-024 After rst deasserts, the first start SHALL be accepted at the next edge.

Verification (WIDTH=8)
REQ-025 a=0x5A, b=0x23, start 1 cycle -> busy high 8 cycles, then done=1 one cycle, diff=0x37, borrow_out=0, zero=0.
REQ-026 a=0x10, b=0x20 -> diff=0xF0, borrow_out=1, zero=0; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-027 a=0x3C, b=0x3C -> diff=0x00, borrow_out=0, zero=1.
REQ-028 start held high continuously with a=0x05,b=0x03 then a=0x03,b=0x05 changed in DONE -> two done pulses 9 cycles apart, results 0x02/0 then 0xFE/1; start pulses inside RUN have no effect.
REQ-029 rst=1 on the 4th RUN cycle -> next cycle busy=0, done=0, diff=0x00, zero=1; no done pulse follows; subsequent start computes correctly.
REQ-030 Exhaustive sweep for WIDTH=4 (all 256 a,b pairs) -> diff and borrow_out match a - b reference model every time.
